bird_motion: RTL and testbench



---
 rtl/bird_motion.sv | 146 ++++++++++++++
 tb/tb_bird_motion.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bird_motion.sv
// bird_motion: flappy-bird game FSM and vertical physics.
// Turns keyboard commands into bird row/velocity, updated once per frame_tick.
module bird_motion #(
  parameter int Y_W      = 10,
  parameter int V_W      = 6,
  parameter int START_Y  = 240,
  parameter int FLOOR_Y  = 440,
  parameter int GRAVITY  = 1,
  parameter int FLAP_V   = 8,
  parameter int MAX_FALL = 10
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic [2:0]            key_state,
  input  logic                  frame_tick,
  input  logic                  collision,
  output logic [Y_W-1:0]        bird_y,
  output logic signed [V_W-1:0] bird_vel,
  output logic                  playing,
  output logic                  dead,
  output logic                  flap_ack
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_DEAD = 2'd2
  } state_t;

  localparam logic [2:0] K_FLAP    = 3'b010;
  localparam logic [2:0] K_RESTART = 3'b111;
  localparam logic signed [V_W:0] LP_GRAV = (V_W+1)'(GRAVITY);
  localparam logic signed [V_W:0] LP_MAXF = (V_W+1)'(MAX_FALL);
  localparam logic signed [V_W:0] LP_FLAP = (V_W+1)'(FLAP_V);
  localparam logic signed [Y_W:0] LP_FLOOR = (Y_W+1)'(FLOOR_Y);
  localparam logic [Y_W-1:0] LP_FLOOR_Y = Y_W'(FLOOR_Y);
  localparam logic [Y_W-1:0] LP_START_Y = Y_W'(START_Y);

  state_t                r_state;
  state_t                w_nstate;
  logic [Y_W-1:0]        r_y;
  logic [Y_W-1:0]        w_ny;
  logic signed [V_W-1:0] r_vel;
  logic signed [V_W-1:0] w_nvel;
  logic                  r_pend;
  logic                  w_npend;
  logic                  r_ack;
  logic                  w_nack;
  logic [2:0]            r_key_prev;

  logic                  w_press;
  logic                  w_restart;
  logic                  w_pend;
  logic                  w_step;
  logic signed [V_W:0]   w_vg;
  logic signed [V_W:0]   w_vnew;
  logic signed [Y_W:0]   w_ysum;

  assign w_press   = (key_state == K_FLAP) && (r_key_prev != K_FLAP);
  assign w_restart = (key_state == K_RESTART);
  // A press landing on the tick cycle is consumed by that tick
  assign w_pend    = r_pend | w_press;
  assign w_step    = frame_tick && ((r_state == S_PLAY) || w_pend);

  assign w_vg   = $signed({r_vel[V_W-1], r_vel}) + LP_GRAV;
  assign w_vnew = w_pend ? -LP_FLAP
                : ((w_vg > LP_MAXF) ? LP_MAXF : w_vg);
  assign w_ysum = $signed({1'b0, r_y})
                + $signed({{(Y_W-V_W){w_vnew[V_W]}}, w_vnew});

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nstate;
    end
  end

  always_comb begin
    w_nstate = r_state;
    w_ny     = r_y;
    w_nvel   = r_vel;
    w_npend  = r_pend;
    w_nack   = 1'b0;
    if (w_restart) begin
      w_nstate = S_IDLE;
      w_ny     = LP_START_Y;
      w_nvel   = '0;
      w_npend  = 1'b0;
    end else begin
      case (r_state)
        S_DEAD: w_npend = 1'b0;
        S_IDLE, S_PLAY: begin
          if ((r_state == S_PLAY) && collision) begin
            w_nstate = S_DEAD;
            w_nvel   = '0;
            w_npend  = 1'b0;
          end else if (w_step) begin
            w_nstate = S_PLAY;
            w_npend  = 1'b0;
            w_nack   = w_pend;
            if (w_ysum[Y_W]) begin
              w_ny   = '0;
              w_nvel = '0;
            end else if (w_ysum >= LP_FLOOR) begin
              w_ny     = LP_FLOOR_Y;
              w_nvel   = '0;
              w_nstate = S_DEAD;
            end else begin
              w_ny   = w_ysum[Y_W-1:0];
              w_nvel = w_vnew[V_W-1:0];
            end
          end else begin
            w_npend = w_pend;
          end
        end
        default: w_nstate = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_y        <= LP_START_Y;
      r_vel      <= '0;
      r_pend     <= 1'b0;
      r_ack      <= 1'b0;
      r_key_prev <= 3'b000;
    end else begin
      r_y        <= w_ny;
      r_vel      <= w_nvel;
      r_pend     <= w_npend;
      r_ack      <= w_nack;
      r_key_prev <= key_state;
    end
  end

  always_comb begin
    playing  = (r_state == S_PLAY);
    dead     = (r_state == S_DEAD);
    bird_y   = r_y;
    bird_vel = r_vel;
    flap_ack = r_ack;
  end

endmodule

// File: tb/tb_bird_motion.sv
// tb_bird_motion: directed and random checks of bird_motion
// against an integer game model.
module tb_bird_motion;

  logic              CLK = 1'b0;
  logic              reset = 1'b0;
  logic [2:0]        key_state = 3'b000;
  logic              frame_tick = 1'b0;
  logic              collision = 1'b0;
  logic [9:0]        bird_y;
  logic signed [5:0] bird_vel;
  logic              playing;
  logic              dead;
  logic              flap_ack;

  int checks = 0;
  int failures = 0;

  bird_motion dut (
    .CLK        (CLK),
    .reset      (reset),
    .key_state  (key_state),
    .frame_tick (frame_tick),
    .collision  (collision),
    .bird_y     (bird_y),
    .bird_vel   (bird_vel),
    .playing    (playing),
    .dead       (dead),
    .flap_ack   (flap_ack)
  );

  always #5 CLK = ~CLK;

  // Game model: st 0=idle 1=play 2=dead
  typedef struct {
    int st;
    int y;
    int v;
    bit pend;
    int prev;
    bit ack;
  } mdl_t;

  localparam mdl_t M_RST = '{st: 0, y: 240, v: 0, pend: 1'b0, prev: 0, ack: 1'b0};

  mdl_t m = M_RST;

  function automatic mdl_t step(mdl_t c, int k, bit t, bit col);
    mdl_t n;
    bit   press;
    bit   pe;
    int   vn;
    int   ys;
    n = c;
    n.prev = k;
    n.ack = 1'b0;
    press = (k == 2) && (c.prev != 2);
    if (k == 7) begin
      n.st = 0; n.y = 240; n.v = 0; n.pend = 1'b0;
    end else if (c.st == 2) begin
      n.pend = 1'b0;
    end else if (c.st == 1 && col) begin
      n.st = 2; n.v = 0; n.pend = 1'b0;
    end else begin
      pe = c.pend || press;
      if (t && (c.st == 1 || pe)) begin
        vn = pe ? -8 : ((c.v + 1 > 10) ? 10 : c.v + 1);
        n.ack = pe;
        n.pend = 1'b0;
        n.st = 1;
        ys = c.y + vn;
        if (ys < 0) begin
          n.y = 0; n.v = 0;
        end else if (ys >= 440) begin
          n.y = 440; n.v = 0; n.st = 2;
        end else begin
          n.y = ys; n.v = vn;
        end
      end else begin
        n.pend = pe;
      end
    end
    return n;
  endfunction

  always @(posedge CLK or posedge reset) begin
    if (reset) m <= M_RST;
    else m <= step(m, int'(key_state), frame_tick, collision);
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    chk("mdl_y", int'(bird_y), m.y);
    chk("mdl_vel", int'(bird_vel), m.v);
    chk("mdl_playing", int'(playing), int'(m.st == 1));
    chk("mdl_dead", int'(dead), int'(m.st == 2));
    chk("mdl_ack", int'(flap_ack), int'(m.ack));
  end

  task automatic cyc(input logic [2:0] k, input bit t, input bit c);
    key_state = k;
    frame_tick = t;
    collision = c;
    @(negedge CLK);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    #1 reset = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    reset = 1'b0;
    chk("rst_y", int'(bird_y), 240);
    chk("rst_vel", int'(bird_vel), 0);
    chk("rst_flags", int'({playing, dead, flap_ack}), 0);

    for (int i = 0; i < 5; i++) begin
      cyc(3'b000, 1'b1, 1'b0);
      cyc(3'b000, 1'b0, 1'b0);
    end
    chk("idle_y", int'(bird_y), 240);
    chk("idle_play", int'(playing), 0);

    cyc(3'b010, 1'b0, 1'b0);
    cyc(3'b010, 1'b1, 1'b0);
    chk("flap1_y", int'(bird_y), 232);
    chk("flap1_v", int'(bird_vel), -8);
    chk("flap1_ack", int'(flap_ack), 1);
    chk("flap1_play", int'(playing), 1);
    cyc(3'b010, 1'b0, 1'b0);
    chk("ack_pulse", int'(flap_ack), 0);
    cyc(3'b010, 1'b1, 1'b0);
    chk("hold2_y", int'(bird_y), 225);
    chk("hold2_v", int'(bird_vel), -7);
    chk("hold2_ack", int'(flap_ack), 0);
    cyc(3'b010, 1'b1, 1'b0);
    chk("hold3_y", int'(bird_y), 219);
    chk("hold3_ack", int'(flap_ack), 0);

    cyc(3'b111, 1'b0, 1'b0);
    chk("rs_y", int'(bird_y), 240);
    chk("rs_play", int'(playing), 0);
    cyc(3'b000, 1'b0, 1'b0);
    cyc(3'b010, 1'b1, 1'b0);
    cyc(3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 36; i++) cyc(3'b000, 1'b1, 1'b0);
    chk("pre_floor_y", int'(bird_y), 439);
    chk("pre_floor_v", int'(bird_vel), 10);
    chk("pre_floor_play", int'(playing), 1);
    cyc(3'b000, 1'b1, 1'b0);
    chk("floor_y", int'(bird_y), 440);
    chk("floor_v", int'(bird_vel), 0);
    chk("floor_dead", int'(dead), 1);
    cyc(3'b010, 1'b1, 1'b0);
    chk("dead_y", int'(bird_y), 440);
    chk("dead_ack", int'(flap_ack), 0);

    cyc(3'b111, 1'b0, 1'b0);
    cyc(3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      cyc(3'b010, 1'b1, 1'b0);
      cyc(3'b000, 1'b0, 1'b0);
    end
    chk("top_y", int'(bird_y), 0);
    chk("top_v", int'(bird_vel), -8);
    cyc(3'b010, 1'b1, 1'b0);
    chk("ceil_y", int'(bird_y), 0);
    chk("ceil_v", int'(bird_vel), 0);
    chk("ceil_ack", int'(flap_ack), 1);
    chk("ceil_play", int'(playing), 1);

    cyc(3'b000, 1'b1, 1'b1);
    chk("coll_dead", int'(dead), 1);
    chk("coll_y", int'(bird_y), 0);
    cyc(3'b111, 1'b0, 1'b0);
    chk("coll_rs_y", int'(bird_y), 240);
    chk("coll_rs_dead", int'(dead), 0);

    cyc(3'b010, 1'b1, 1'b0);
    cyc(3'b111, 1'b0, 1'b1);
    chk("rs_wins", int'({playing, dead}), 0);

    cyc(3'b000, 1'b0, 1'b0);
    cyc(3'b010, 1'b1, 1'b0);
    chk("pre_ar_play", int'(playing), 1);
    #2 reset = 1'b1;
    #1;
    chk("ar_y", int'(bird_y), 240);
    chk("ar_vel", int'(bird_vel), 0);
    chk("ar_flags", int'({playing, dead, flap_ack}), 0);
    @(negedge CLK);
    reset = 1'b0;

    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 99);
      cyc((r < 2) ? 3'b111 : (r < 40) ? 3'b010 : (r < 60) ? 3'b100 : 3'b000,
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
